// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the SAR ADC conversion sequencer.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_t;

  // Conversions averaged per channel when averaging is compiled in.
  localparam int AVG_N  = 4;
  localparam int AVG_SH = $clog2(AVG_N);

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_sel_w(input int num_ch);
    int w;
    w = $clog2(num_ch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sar_adc_next_ch.sv
// Picks the next enabled channel strictly above i_cur, else wraps to the lowest.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module sar_adc_next_ch
  import sar_adc_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  output logic [CH_W-1:0]   o_next,
  output logic              o_wrap
);

  logic            w_found_hi;
  logic [CH_W-1:0] w_hi;
  logic [CH_W-1:0] w_lo;

  // Scan downwards so the last hit is the lowest match in each category.
  always_comb begin
    w_found_hi = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_lo = CH_W'(i);
        if (CH_W'(i) > i_cur) begin
          w_hi       = CH_W'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    o_wrap = !w_found_hi;
    o_next = w_found_hi ? w_hi : w_lo;
  end

endmodule

// File: rtl/sar_adc_seq.sv
// Multi-channel SAR ADC sequencer: sample, binary search on cmp_i, scan channel mask.
// Latency: SAMPLE_CYC + WIDTH*SETTLE_CYC + 1 cycles per channel (x4 with SAR_ADC_SEQ_AVG_EN).
// Backpressure: one-entry valid/ready result buffer; a result arriving while full is dropped and flags overrun_o.
module sar_adc_seq
  import sar_adc_pkg::*;
#(
  parameter  int WIDTH      = 10,
  parameter  int NUM_CH     = 4,
  parameter  int SAMPLE_CYC = 4,
  parameter  int SETTLE_CYC = 2,
  localparam int CH_W       = ch_sel_w(NUM_CH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic              cmp_i,
  output logic              sample_o,
  output logic [CH_W-1:0]   ch_sel_o,
  output logic [WIDTH-1:0]  dac_code_o,
  output logic              busy_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [CH_W-1:0]   result_ch_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              overrun_o,
  input  logic              clr_ovr_i
);

  localparam int MAXC  = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int BIT_W = $clog2(WIDTH);

  sar_state_t        r_state;
  sar_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic [WIDTH-1:0]  r_code;
  logic [NUM_CH-1:0] r_mask;
  logic [CH_W-1:0]   r_ch;
  logic [WIDTH-1:0]  r_res;
  logic [CH_W-1:0]   r_res_ch;
  logic              r_vld;
  logic              r_ovr;

  logic              w_smp_last;
  logic              w_set_last;
  logic              w_start_ok;
  logic              w_last_pass;
  logic              w_push;
  logic [WIDTH-1:0]  w_res;
  logic [NUM_CH-1:0] w_nc_mask;
  logic [CH_W-1:0]   w_nc_cur;
  logic [CH_W-1:0]   w_next_ch;
  logic              w_wrap;

  assign w_smp_last = (r_cnt == CNT_W'(SAMPLE_CYC - 1));
  assign w_set_last = (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_start_ok = (r_state == IDLE) && start_i && (|ch_mask_i);
  assign w_push     = (r_state == DONE) && w_last_pass;

  // In IDLE, searching above the top channel always wraps, so the encoder
  // yields the lowest enabled channel of the incoming mask.
  assign w_nc_mask = (r_state == IDLE) ? ch_mask_i : r_mask;
  assign w_nc_cur  = (r_state == IDLE) ? CH_W'(NUM_CH - 1) : r_ch;

  sar_adc_next_ch #(
    .NUM_CH (NUM_CH)
  ) u_next_ch (
    .i_mask (w_nc_mask),
    .i_cur  (w_nc_cur),
    .o_next (w_next_ch),
    .o_wrap (w_wrap)
  );

`ifdef SAR_ADC_SEQ_AVG_EN
  localparam int PASS_W = AVG_SH;

  logic [PASS_W-1:0]       r_pass;
  logic [WIDTH+AVG_SH-1:0] r_acc;
  logic [WIDTH+AVG_SH-1:0] w_sum;

  assign w_sum       = r_acc + {{AVG_SH{1'b0}}, r_code};
  assign w_last_pass = (r_pass == PASS_W'(AVG_N - 1));
  assign w_res       = w_sum[AVG_SH +: WIDTH];

  // Accumulate each pass of a channel; the final pass clears for the next channel.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_pass <= '0;
      r_acc  <= '0;
    end else if (r_state == DONE) begin
      if (w_last_pass) begin
        r_pass <= '0;
        r_acc  <= '0;
      end else begin
        r_pass <= r_pass + 1'b1;
        r_acc  <= w_sum;
      end
    end
  end
`else
  assign w_last_pass = 1'b1;
  assign w_res       = r_code;
`endif

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state decode and the analog-facing control outputs.
  always_comb begin
    w_state_nxt = r_state;
    sample_o    = 1'b0;
    busy_o      = 1'b1;
    dac_code_o  = '0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (w_start_ok) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        sample_o = 1'b1;
        if (w_smp_last) w_state_nxt = CONVERT;
      end
      CONVERT: begin
        dac_code_o = r_code | (WIDTH'(1) << r_bit);
        if (w_set_last && (r_bit == '0)) w_state_nxt = DONE;
      end
      DONE: begin
        // cont_i only matters when the scan wraps past the top enabled channel.
        if (!w_last_pass || !w_wrap || cont_i) w_state_nxt = SAMPLE;
        else                                  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Cycle counter, bit index and successive-approximation register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_code <= '0;
    end else begin
      case (r_state)
        SAMPLE: begin
          r_cnt  <= w_smp_last ? '0 : r_cnt + 1'b1;
          r_bit  <= BIT_W'(WIDTH - 1);
          r_code <= '0;
        end
        CONVERT: begin
          if (w_set_last) begin
            r_cnt         <= '0;
            r_code[r_bit] <= cmp_i;
            if (r_bit != '0) r_bit <= r_bit - 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Captured mask and current channel.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_mask <= '0;
      r_ch   <= '0;
    end else if (w_start_ok) begin
      r_mask <= ch_mask_i;
      r_ch   <= w_next_ch;
    end else if (w_push && (!w_wrap || cont_i)) begin
      r_ch   <= w_next_ch;
    end
  end

  // One-entry result buffer with sticky overrun; a new overrun beats a clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_res    <= '0;
      r_res_ch <= '0;
      r_vld    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_push && (!r_vld || result_ready_i)) begin
        r_res    <= w_res;
        r_res_ch <= r_ch;
        r_vld    <= 1'b1;
      end else if (r_vld && result_ready_i) begin
        r_vld    <= 1'b0;
      end
      if (w_push && r_vld && !result_ready_i) r_ovr <= 1'b1;
      else if (clr_ovr_i)                     r_ovr <= 1'b0;
    end
  end

  assign ch_sel_o       = r_ch;
  assign result_o       = r_res;
  assign result_ch_o    = r_res_ch;
  assign result_valid_o = r_vld;
  assign overrun_o      = r_ovr;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Self-checking bench for sar_adc_seq with an ideal comparator and a result scoreboard.
// Latency: checks the per-channel conversion time against the parameter formula.
// Backpressure: exercises held results, dropped results and the overrun flag.
module tb_sar_adc_seq;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       start    = 1'b0;
  logic       cont     = 1'b0;
  logic [3:0] mask     = 4'b0;
  logic       cmp;
  logic       smp;
  logic [1:0] ch_sel;
  logic [9:0] dac;
  logic       busy;
  logic [9:0] res;
  logic [1:0] res_ch;
  logic       res_vld;
  logic       res_rdy  = 1'b1;
  logic       ovr;
  logic       clr_ovr  = 1'b0;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] code;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         n_res    = 0;
  logic [9:0] vin [4];

  always #5 clk = ~clk;

  // Ideal comparator: input voltage code against the DAC trial code.
  assign cmp = (vin[ch_sel] >= dac);

  sar_adc_seq dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (rst_n),
    .start_i        (start),
    .cont_i         (cont),
    .ch_mask_i      (mask),
    .cmp_i          (cmp),
    .sample_o       (smp),
    .ch_sel_o       (ch_sel),
    .dac_code_o     (dac),
    .busy_o         (busy),
    .result_o       (res),
    .result_ch_o    (res_ch),
    .result_valid_o (res_vld),
    .result_ready_i (res_rdy),
    .overrun_o      (ovr),
    .clr_ovr_i      (clr_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] c, input logic [9:0] code);
    exp_t e;
    e.ch   = c;
    e.code = code;
    sb.push_back(e);
  endtask

  // Scoreboard: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_vld && res_rdy) begin
      n_res++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_vld", 32'(res_vld), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res_ch", 32'(res_ch), 32'(e.ch));
        chk("res_code", 32'(res), 32'(e.code));
      end
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_sample"}, 32'(smp), 0);
    chk({pfx, "_ch_sel"}, 32'(ch_sel), 0);
    chk({pfx, "_dac"}, 32'(dac), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_result"}, 32'(res), 0);
    chk({pfx, "_result_ch"}, 32'(res_ch), 0);
    chk({pfx, "_valid"}, 32'(res_vld), 0);
    chk({pfx, "_overrun"}, 32'(ovr), 0);
  endtask

  task automatic start_scan(input logic [3:0] m, input logic c);
    @(posedge clk); #1;
    start = 1'b1;
    mask  = m;
    cont  = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) vin[i] = '0;
    #2 rst_n = 1'b0;
    #2 chk_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef SAR_ADC_SEQ_AVG_EN
    begin
      logic [9:0] tbl [4];
      int lat;
      tbl[0] = 10'h100; tbl[1] = 10'h101; tbl[2] = 10'h101; tbl[3] = 10'h103;
      vin[0] = tbl[0];
      push_exp(2'd0, 10'h101);
      start_scan(4'b0001, 1'b0);
      lat = 0;
      while (!res_vld && lat < 400) begin
        @(posedge clk); #1;
        lat++;
        if ((lat % 25) == 0 && lat < 100) vin[0] = tbl[lat / 25];
      end
      chk("avg_latency", 32'(lat), 32'd100);
      wait_idle(200);
      chk("avg_sb_drained", 32'(sb.size()), 0);
    end
`else
    // Single channel, latency from the rising edge of sample_o.
    begin
      int lat;
      vin[0] = 10'h2A5;
      push_exp(2'd0, 10'h2A5);
      start_scan(4'b0001, 1'b0);
      chk("t1_sample_hi", 32'(smp), 1);
      chk("t1_ch_sel", 32'(ch_sel), 0);
      chk("t1_dac_in_sample", 32'(dac), 0);
      lat = 0;
      while (!res_vld && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("t1_latency", 32'(lat), 32'd25);
      wait_idle(100);
    end

    // Sparse mask: order ch1 then ch3, mid-scale and full-scale codes.
    vin[1] = 10'h100; vin[3] = 10'h3FF;
    push_exp(2'd1, 10'h100);
    push_exp(2'd3, 10'h3FF);
    start_scan(4'b1010, 1'b0);
    chk("t2_first_ch", 32'(ch_sel), 1);
    wait_idle(200);
    vin[1] = 10'h000;
    push_exp(2'd1, 10'h000);
    push_exp(2'd3, 10'h3FF);
    start_scan(4'b1010, 1'b0);
    wait_idle(200);
    chk("t2_sb_drained", 32'(sb.size()), 0);

    // Continuous scan, dropped mid-scan: the current scan still completes.
    begin
      int base;
      int k;
      vin[0] = 10'h055; vin[3] = 10'h2AA;
      for (int i = 0; i < 3; i++) begin
        push_exp(2'd0, 10'h055);
        push_exp(2'd3, 10'h2AA);
      end
      base = n_res;
      start_scan(4'b1001, 1'b1);
      k = 0;
      while (n_res < base + 4 && k < 400) begin
        @(posedge clk); #1;
        k++;
      end
      chk("t3_in_ch0", 32'(ch_sel), 0);
      cont = 1'b0;
      wait_idle(200);
      chk("t3_result_count", 32'(n_res - base), 32'd6);
      chk("t3_sb_drained", 32'(sb.size()), 0);
    end

    // Stalled consumer: first result held, second dropped, overrun set.
    vin[0] = 10'h123; vin[1] = 10'h321;
    res_rdy = 1'b0;
    push_exp(2'd0, 10'h123);
    start_scan(4'b0011, 1'b0);
    wait_idle(200);
    chk("t4_held_vld", 32'(res_vld), 1);
    chk("t4_held_res", 32'(res), 32'h123);
    chk("t4_held_ch", 32'(res_ch), 0);
    chk("t4_overrun", 32'(ovr), 1);
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
    chk("t4_drained", 32'(res_vld), 0);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    chk("t4_ovr_cleared", 32'(ovr), 0);

    // Fill the buffer, then land a clear in the same cycle as a new overrun.
    push_exp(2'd0, 10'h123);
    start_scan(4'b0001, 1'b0);
    wait_idle(100);
    start_scan(4'b0001, 1'b0);
    repeat (24) @(posedge clk);
    #1;
    chk("t4_ovr_before_done", 32'(ovr), 0);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    chk("t4_set_beats_clear", 32'(ovr), 1);
    chk("t4_still_held", 32'(res), 32'h123);
    res_rdy = 1'b1;
    wait_idle(50);
    chk("t4_sb_drained", 32'(sb.size()), 0);

    // Reset in the middle of CONVERT aborts with no result.
    begin
      logic seen_vld;
      vin[0] = 10'h3C3;
      start_scan(4'b0001, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("t5_busy_convert", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1 chk_zero("t5_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen_vld = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        seen_vld = seen_vld | res_vld;
      end
      chk("t5_no_result", 32'(seen_vld), 0);
      start_scan(4'b0000, 1'b0);
      chk("t5_zero_mask_ignored", 32'(busy), 0);
      @(posedge clk); #1;
      chk("t5_zero_mask_idle", 32'(busy), 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

endmodule
